// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
package uart_pkg;

   localparam int DATA_W            = 8;
   localparam int FIFO_DEPTH_DEF    = 4;
   localparam int TIMEOUT_TICKS_DEF = 640;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ACTIVE   = 2'd1,
      ST_FLUSH    = 2'd2
   } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO with occupancy count and a registered head byte
// that keeps its last value while the FIFO is empty.
module rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW-1:0]     rd_ptr_d;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] head_d;
   logic              do_push;
   logic              do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

   // A clear wins over both pop and push; a push into a full FIFO only
   // proceeds when a pop frees a slot in the same cycle.
   assign do_pop   = pop_i && !empty_o && !clear_i;
   assign do_push  = push_i && (!full_o || do_pop) && !clear_i;
   assign rd_ptr_d = rd_ptr_q + AW'(do_pop);
   assign count_d  = count_q + CW'(do_push) - CW'(do_pop);

   // Select the byte that will be at the head after this cycle's update.
   always_comb begin
      // NOTE: default first so every path assigns head_d and no latch is inferred.
      head_d = mem_q[rd_ptr_d];
      if (do_push && (wr_ptr_q == rd_ptr_d)) begin
         head_d = wdata_i;
      end
   end

   // Pointer, count and head-byte registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (count_d != '0) begin
            rdata_q <= head_d;
         end
      end
   end

   // Byte storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array is not reset; pointers and count define which entries are valid.
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = rdata_q;
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, strobe synchronizer,
// receive FIFO with overrun flag, and an idle-line timeout.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
   parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic [15:0]                   baud_div,
   input  logic                          flush,
   output logic                          s_tick,
   input  logic                          rx_doneTick,
   input  logic [DATA_W-1:0]             rx_dataOut,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   input  logic                          overrun_clr,
   output logic                          idle_timeout
);

   localparam int IW = $clog2(TIMEOUT_TICKS + 1);

   rx_state_e     state_q;
   logic [15:0]   eff_div;
   logic [15:0]   baud_cnt_q;
   logic [15:0]   baud_cnt_d;
   logic          sync1_q;
   logic          sync2_q;
   logic          sync3_q;
   logic          capture;
   logic          push;
   logic          pop;
   logic          clear;
   logic          fifo_full;
   logic          fifo_empty;
   logic          overrun_q;
   logic          overrun_set;
   logic [IW-1:0] idle_cnt_q;
   logic [IW-1:0] idle_cnt_d;
   logic          idle_hit;
   logic          idle_q;

   // Operating mode: en=0 always forces DISABLED; FLUSH lasts exactly one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_DISABLED;
      end else if (!en) begin
         state_q <= ST_DISABLED;
      end else begin
         case (state_q)
            ST_DISABLED: state_q <= ST_ACTIVE;
            ST_ACTIVE:   if (flush) state_q <= ST_FLUSH;
            default:     state_q <= ST_ACTIVE;
         endcase
      end
   end

   // Divisors below 2 are clamped so the tick never becomes a constant level.
   assign eff_div = (baud_div < 16'd2) ? 16'd2 : baud_div;
   assign s_tick  = (state_q == ST_ACTIVE) && (baud_cnt_q >= eff_div - 16'd1);

   // Baud counter next value: runs only in ACTIVE and wraps on each tick.
   always_comb begin
      baud_cnt_d = '0;
      if ((state_q == ST_ACTIVE) && !s_tick) begin
         baud_cnt_d = baud_cnt_q + 16'd1;
      end
   end

   // Baud counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) baud_cnt_q <= '0;
      else       baud_cnt_q <= baud_cnt_d;
   end

   // Two-flop synchronizer plus a history flop for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= rx_doneTick;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign capture     = sync2_q && !sync3_q;
   assign push        = capture && (state_q == ST_ACTIVE);
   assign pop         = rd_ready && !fifo_empty;
   assign clear       = (state_q == ST_FLUSH);
   assign overrun_set = push && fifo_full && !pop;

   rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .clear_i (clear),
      .push_i  (push),
      .wdata_i (rx_dataOut),
      .pop_i   (pop),
      .rdata_o (rd_data),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Sticky overrun flag; a new drop beats a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            overrun_q <= 1'b0;
      else if (overrun_set) overrun_q <= 1'b1;
      else if (overrun_clr) overrun_q <= 1'b0;
   end

   // Idle counter next value: cleared by line activity, saturates at the limit.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (push || clear) begin
         idle_cnt_d = '0;
      end else if (s_tick && (idle_cnt_q != IW'(TIMEOUT_TICKS))) begin
         idle_cnt_d = idle_cnt_q + IW'(1);
      end
   end

   // Reaching the limit happens once per push because the counter then saturates.
   assign idle_hit = !push && !clear && s_tick && (idle_cnt_q == IW'(TIMEOUT_TICKS - 1));

   // Idle counter and registered timeout pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_cnt_q <= '0;
         idle_q     <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         idle_q     <= idle_hit && !fifo_empty;
      end
   end

   assign rd_valid     = !fifo_empty;
   assign overrun      = overrun_q;
   assign idle_timeout = idle_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized
// phase, all compared against a queue-based model of the receive FIFO.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;
   localparam int TMO   = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [15:0] baud_div = 16'd10;
   logic        flush = 1'b0;
   logic        s_tick;
   logic        rx_doneTick = 1'b0;
   logic [7:0]  rx_dataOut = 8'h00;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic [2:0]  fifo_count;
   logic        overrun;
   logic        overrun_clr = 1'b0;
   logic        idle_timeout;

   uart_rx_ctrl #(
      .FIFO_DEPTH    (DEPTH),
      .TIMEOUT_TICKS (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .baud_div     (baud_div),
      .flush        (flush),
      .s_tick       (s_tick),
      .rx_doneTick  (rx_doneTick),
      .rx_dataOut   (rx_dataOut),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .fifo_count   (fifo_count),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr),
      .idle_timeout (idle_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state
   logic [7:0] mq[$];
   bit         m_ovr  = 1'b0;
   logic [7:0] m_last = 8'h00;
   int         cap_cd = 0;     // edges until the current strobe is captured
   bit         accept = 1'b1;  // controller is in ACTIVE when the capture lands
   int         push_cyc = 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given rd_ready / overrun_clr, then model update and checks.
   task automatic tick(input bit rdy = 1'b0, input bit clr = 1'b0);
      bit         do_pop;
      bit         do_push;
      bit         drop;
      logic [7:0] pb;
      rd_ready    = rdy;
      overrun_clr = clr;
      do_pop  = (mq.size() > 0) && rdy;
      do_push = (cap_cd == 1) && accept;
      pb      = rx_dataOut;
      if (cap_cd > 0) cap_cd--;
      @(posedge clk);
      #1;
      overrun_clr = 1'b0;
      drop = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         push_cyc = cyc;
         if (mq.size() < DEPTH) mq.push_back(pb);
         else drop = 1'b1;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      if (mq.size() > 0) m_last = mq[0];
      check("fifo_count", 32'(fifo_count), 32'(mq.size()));
      check("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      check("rd_data", 32'(rd_data), 32'(m_last));
      check("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   // Receiver strobe: two cycles high, three low; bit i of each mask applies to tick i.
   task automatic strobe(input logic [7:0] b, input bit [4:0] rdy = '0, input bit [4:0] clr = '0);
      rx_dataOut  = b;
      rx_doneTick = 1'b1;
      cap_cd      = 3;
      tick(rdy[0], clr[0]);
      tick(rdy[1], clr[1]);
      rx_doneTick = 1'b0;
      for (int i = 2; i < 5; i++) tick(rdy[i], clr[i]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ts[$];
      int n_hi;
      int n_idle;
      int idle_d;
      int gap;

      // Reset values while reset is held
      #1;
      check("rst_s_tick", 32'(s_tick), 0);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_fifo_count", 32'(fifo_count), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_idle", 32'(idle_timeout), 0);

      @(posedge clk);
      #1;
      reset    = 1'b0;
      en       = 1'b1;
      baud_div = 16'd10;
      tick();

      // Tick period 10 with baud_div=10
      ts.delete();
      for (int i = 0; i < 60; i++) begin
         tick();
         if (s_tick) ts.push_back(cyc);
      end
      check("stick10_pulses", 32'(ts.size() >= 5), 1);
      for (int i = 1; i < ts.size(); i++) check("stick10_period", 32'(ts[i] - ts[i-1]), 10);

      // baud_div=1 clamps to a period of 2
      baud_div = 16'd1;
      for (int i = 0; i < 3; i++) tick();
      ts.delete();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_tick) ts.push_back(cyc);
      end
      check("stick1_pulses", 32'(ts.size() >= 8), 1);
      for (int i = 1; i < ts.size(); i++) check("stick1_period", 32'(ts[i] - ts[i-1]), 2);

      // Disabled: no ticks
      en = 1'b0;
      tick();
      n_hi = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_tick) n_hi++;
      end
      check("stick_disabled", 32'(n_hi), 0);
      en = 1'b1;
      tick();
      baud_div = 16'd1000;

      // Three bytes streamed straight through to the consumer
      strobe(8'h55, 5'b11111);
      strobe(8'hA3, 5'b11111);
      strobe(8'h0F, 5'b11111);
      check("stream_last", 32'(rd_data), 32'h0F);

      // Five pushes into a depth-4 FIFO with no consumer
      strobe(8'h10);
      strobe(8'h20);
      strobe(8'h30);
      strobe(8'h40);
      strobe(8'h50);
      check("full_count", 32'(fifo_count), 4);
      check("full_overrun", 32'(overrun), 1);
      check("full_head", 32'(rd_data), 32'h10);
      tick(1'b0, 1'b1);
      check("ovr_cleared", 32'(overrun), 0);

      // Full FIFO: push and pop on the same edge
      strobe(8'h99, 5'b00100);
      check("pushpop_count", 32'(fifo_count), 4);
      check("pushpop_ovr", 32'(overrun), 0);
      check("pushpop_head", 32'(rd_data), 32'h20);

      // Drop and overrun_clr on the same edge: set wins
      strobe(8'hE7, 5'b00000, 5'b00100);
      check("ovr_set_wins", 32'(overrun), 1);
      tick(1'b1);
      tick(1'b1);
      check("order_head", 32'(rd_data), 32'h40);

      // Flush with a pop request in the flush cycle
      rd_ready = 1'b0;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      rd_ready = 1'b1;
      @(posedge clk);
      #1;
      rd_ready = 1'b0;
      mq.delete();
      check("flush_count", 32'(fifo_count), 0);
      check("flush_valid", 32'(rd_valid), 0);
      check("flush_ovr", 32'(overrun), 1);
      check("flush_rd_hold", 32'(rd_data), 32'(m_last));
      tick(1'b0, 1'b1);

      // Idle timeout: one byte waiting, 64 ticks of period 2
      baud_div = 16'd2;
      strobe(8'h6B);
      n_idle = 0;
      idle_d = -1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (idle_timeout) begin
            n_idle++;
            if (n_idle == 1) idle_d = cyc - push_cyc;
         end
      end
      check("idle_pulses", 32'(n_idle), 1);
      check("idle_delay", 32'((idle_d >= 127) && (idle_d <= 128)), 1);
      baud_div = 16'd1000;

      // Contents retained and poppable while disabled; captures discarded
      strobe(8'hC4);
      en = 1'b0;
      tick();
      accept = 1'b0;
      strobe(8'h11);
      check("dis_count", 32'(fifo_count), 2);
      tick(1'b1);
      check("dis_pop_head", 32'(rd_data), 32'hC4);
      tick(1'b1);
      tick(1'b1);
      en = 1'b1;
      tick();
      accept = 1'b1;

      // Randomized traffic
      for (int k = 0; k < 60; k++) begin
         strobe(8'($urandom), 5'($urandom) & 5'($urandom),
                5'($urandom) & 5'($urandom) & 5'($urandom));
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick(1'($urandom));
      end
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);

      // Reset in the middle of a stream with three bytes queued
      strobe(8'hA1);
      strobe(8'hB2);
      strobe(8'hC3);
      check("pre_rst_count", 32'(fifo_count), 3);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(rd_valid), 0);
      check("mid_rst_count", 32'(fifo_count), 0);
      check("mid_rst_data", 32'(rd_data), 0);
      check("mid_rst_ovr", 32'(overrun), 0);
      check("mid_rst_stick", 32'(s_tick), 0);
      mq.delete();
      m_ovr  = 1'b0;
      m_last = 8'h00;
      cap_cd = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      strobe(8'h3C);
      check("post_rst_count", 32'(fifo_count), 1);
      check("post_rst_data", 32'(rd_data), 32'h3C);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, 4, receive FIFO depth in bytes (power of two, 2..16).
REQ-002 Parameter TIMEOUT_TICKS, 640, idle s_tick count before idle_timeout fires (40 bit-times at 16x oversampling).
REQ-003 clk  in  1  single system clock; all state is on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  level enable; 0 stops s_tick generation and byte capture.
REQ-006 baud_div  in  16  clk cycles per s_tick (16x oversample rate).
REQ-007 flush  in  1  single-cycle request to empty the FIFO.
REQ-008 s_tick  out  1  one-clk-wide oversample enable to the receiver.
REQ-009 rx_doneTick  in  1  receiver byte-done strobe (asynchronous to clk, at least 2 clk wide).
REQ-010 rx_dataOut  in  8  receiver byte, stable while rx_doneTick is high and until the next frame.
REQ-011 rd_data  out  8  FIFO head byte.
REQ-012 rd_valid  out  1  FIFO non-empty.
REQ-013 rd_ready  in  1  consumer accepts rd_data when rd_valid=1.
REQ-014 fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
REQ-015 overrun  out  1  sticky: a byte was dropped because the FIFO was full.
REQ-016 overrun_clr  in  1  single-cycle clear for overrun.
REQ-017 idle_timeout  out  1  one-clk pulse: FIFO non-empty and line idle for TIMEOUT_TICKS.

Function
REQ-018 States SHALL be DISABLED, ACTIVE and FLUSH; DISABLED->ACTIVE when en=1; any state->DISABLED when en=0; ACTIVE->FLUSH on flush=1; FLUSH->ACTIVE (en=1) or DISABLED (en=0) after exactly one cycle.
REQ-019 Baud counter: in ACTIVE, increments each clk; when count >= eff_div-1, s_tick=1 for that cycle and count wraps to 0; eff_div = max(baud_div, 2).
REQ-020 In DISABLED and FLUSH, the baud counter SHALL be held at 0 and s_tick=0.
REQ-021 A baud_div change SHALL take effect on the next cycle with no glitch wider than one s_tick.
REQ-022 rx_doneTick SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal is one capture event, latency 3 clk from the input edge.
REQ-023 On a capture event in ACTIVE, rx_dataOut SHALL be pushed; capture events in DISABLED and FLUSH are discarded and do not set overrun.
REQ-024 Pop occurs when rd_valid and rd_ready are both 1; rd_data SHALL present the new head on the next cycle.
REQ-025 Full FIFO + push + no pop: the byte is dropped, the FIFO is unchanged, and overrun is set on the next cycle.
REQ-026 Full FIFO + push + pop in the same cycle: both SHALL proceed, fifo_count is unchanged, and no overrun.
REQ-027 Empty FIFO + push + rd_ready: no pop that cycle; rd_valid=1 on the next cycle (no fall-through).
REQ-028 Empty FIFO: rd_valid=0 and rd_data holds its last value.
REQ-029 overrun_clr and a new overrun in the same cycle: set SHALL win.
REQ-030 FLUSH SHALL empty the FIFO in one cycle, ignore a pop that cycle, and leave overrun unchanged.
REQ-031 Idle counter: counts s_ticks, is cleared on push or flush, and saturates at TIMEOUT_TICKS; idle_timeout pulses once when the count reaches TIMEOUT_TICKS with fifo_count>0, and does not repeat until the next push.
REQ-032 FIFO contents SHALL be retained across ACTIVE->DISABLED and remain poppable in DISABLED.

Reset
REQ-033 reset asserted SHALL immediately force: state DISABLED, s_tick=0, rd_valid=0, rd_data=0, fifo_count=0, overrun=0, idle_timeout=0, all counters and synchronizer flops 0.
REQ-034 Reset mid-frame or mid-pop SHALL discard all FIFO contents; the first capture edge after release requires a fresh 0->1 transition of the synchronized rx_doneTick.

Structure
REQ-035 Package uart_pkg SHALL hold the state enum, the data width constant (8) and the FIFO_DEPTH and TIMEOUT_TICKS defaults.
REQ-036 The FIFO SHALL be a sub-module rx_fifo (synchronous, with count output); all other logic lives in uart_rx_ctrl.

Verification
REQ-037 baud_div=10, en=1: s_tick pulses every 10 clk; set baud_div=1 -> s_tick every 2 clk; en=0 -> s_tick stays 0.
REQ-038 Three rx_doneTick pulses with bytes 0x55, 0xA3, 0x0F, rd_ready=1: rd_data sequence 0x55, 0xA3, 0x0F, each appearing 3-4 clk after its strobe.
REQ-039 rd_ready=0, push 5 bytes with FIFO_DEPTH=4: fifo_count=4, overrun=1, 5th byte lost; overrun_clr -> overrun=0.
REQ-040 Full FIFO, push and pop in the same cycle: fifo_count stays 4, overrun stays 0, order preserved.
REQ-041 One byte pushed, TIMEOUT_TICKS=64, baud_div=2: idle_timeout pulses exactly once, 128 clk after the push.
REQ-042 Reset asserted mid-stream with 3 bytes queued: all outputs 0 immediately; after release, the next strobe yields fifo_count=1.
